// File: rtl/prio_req_pkg.sv
// ---------------------------------------------------------------------------
// prio_req_pkg
// Shared definitions for the priority request controller.
//   N_DEFAULT : default number of request lines
//   idw_f()   : id width for a given number of lines ($clog2, minimum 1)
//   state_e   : handshake FSM states (IDLE, OFFER)
// ---------------------------------------------------------------------------
package prio_req_pkg;

    localparam int N_DEFAULT = 8;

    // Id width needed to name any of n lines. The floor of 1 keeps
    // degenerate widths out of the port list.
    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage : prio_req_pkg

// File: rtl/prio_enc_n.sv
// ---------------------------------------------------------------------------
// prio_enc_n
// Combinational highest-index priority encoder.
// Ports:
//   in_vec [N-1:0]   input bit vector
//   idx    [IDW-1:0] index of the highest set bit (0 when none set)
//   any              1 when any bit of in_vec is set
// ---------------------------------------------------------------------------
module prio_enc_n
    import prio_req_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = idw_f(N)
) (
    input  logic [N-1:0]   in_vec,
    output logic [IDW-1:0] idx,
    output logic           any
);

    // The scan runs upward, so the last hit (highest index) wins.
    // NOTE: every output gets a default before the loop; without it a
    // combinational block that assigns only on some paths infers a latch.
    always_comb begin
        idx = '0;
        any = |in_vec;
        for (int i = 0; i < N; i++) begin
            if (in_vec[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule : prio_enc_n

// File: rtl/priority_req_ctrl.sv
// ---------------------------------------------------------------------------
// priority_req_ctrl
// Collects request lines into a sticky pending register and offers the
// highest-index pending id downstream under a valid/ready handshake. The
// accepted id's pending bit is cleared on the handshake; a request arriving
// on that same bit in the same cycle wins and keeps it pending.
//
// Optional feature: define PRIO_REQ_MASK_EN to add the mask port. Masked
// lines still latch into pending but are not selected.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   req     [N-1:0]     request lines, a 1 sets the pending bit
//   mask    [N-1:0]     selection enable per line (PRIO_REQ_MASK_EN only)
//   dout    [IDW-1:0]   offered id
//   valid               dout is valid
//   ready               consumer accepts dout this cycle
//   pending [N-1:0]     current pending register
//   busy                pending non-zero or an offer outstanding
// ---------------------------------------------------------------------------
module priority_req_ctrl
    import prio_req_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = idw_f(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
`ifdef PRIO_REQ_MASK_EN
    input  logic [N-1:0]   mask,
`endif
    output logic [IDW-1:0] dout,
    output logic           valid,
    input  logic           ready,
    output logic [N-1:0]   pending,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [IDW-1:0] dout_q, dout_d;
    logic           valid_q, valid_d;

    logic [N-1:0]   eligible;
    logic [N-1:0]   clr;
    logic [IDW-1:0] sel;
    logic           sel_any;
    logic           handshake;

    assign handshake = valid_q && ready;

`ifdef PRIO_REQ_MASK_EN
    assign eligible = pending_q & mask;
`else
    assign eligible = pending_q;
`endif

    // Selection looks only at the registered pending bits, so a request
    // reaches the output no earlier than two edges after it is raised.
    prio_enc_n #(
        .N   (N),
        .IDW (IDW)
    ) u_enc (
        .in_vec (eligible),
        .idx    (sel),
        .any    (sel_any)
    );

    // Pending update: clear the accepted bit, then OR in new requests so
    // a same-cycle request on the cleared bit survives.
    always_comb begin
        clr = '0;
        if (handshake) begin
            clr[dout_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | req;
    end

    // State register. Reset also clears pending, which drops any offer in
    // flight without performing its clear.
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples the pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic. OFFER only leaves on acceptance: later arrivals of
    // higher priority never preempt the id already on offer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_any)   state_d = OFFER;
            OFFER:   if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs. dout keeps its last value after a grant; only
    // valid qualifies it.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (sel_any) begin
                    dout_d  = sel;
                    valid_d = 1'b1;
                end
            end
            OFFER: begin
                if (handshake) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign busy    = (|pending_q) || valid_q;

endmodule : priority_req_ctrl
